// File: rtl/mem_arbiter.sv
// mem_arbiter: fetch/data arbiter onto one single-port memory, data-first with a fetch starvation guard
module mem_arbiter #(
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 32,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              if_req_i,
   input  logic [ADDR_W-1:0] if_addr_i,
   output logic              if_gnt_o,
   output logic              if_rvalid_o,
   output logic [DATA_W-1:0] if_rdata_o,
   input  logic              d_req_i,
   input  logic              d_we_i,
   input  logic [ADDR_W-1:0] d_addr_i,
   input  logic [DATA_W-1:0] d_wdata_i,
   output logic              d_gnt_o,
   output logic              d_rvalid_o,
   output logic [DATA_W-1:0] d_rdata_o,
   output logic              mem_req_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   input  logic [DATA_W-1:0] mem_rdata_i,
   output logic [31:0]       conflict_cnt_o
);
   typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_D} owner_e;
   owner_e      owner_q, owner_d;
   logic        we_q, we_d;
   logic [3:0]  starve_q, starve_d;
   logic [31:0] conflict_q, conflict_d;
   logic        if_win;
   always_comb begin
      if_win      = if_req_i && (!d_req_i || starve_q == 4'(STARVE_LIMIT));
      if_gnt_o    = rst_n && if_win;
      d_gnt_o     = rst_n && d_req_i && !if_win;
      mem_req_o   = if_gnt_o || d_gnt_o;
      mem_we_o    = d_gnt_o && d_we_i;
      mem_addr_o  = d_gnt_o ? d_addr_i : if_addr_i;
      mem_wdata_o = d_wdata_i;
      owner_d     = if_gnt_o ? OWN_IF : d_gnt_o ? OWN_D : OWN_NONE;
      we_d        = mem_we_o;
      starve_d    = (!if_req_i || if_gnt_o) ? 4'd0 :
                    starve_q == 4'(STARVE_LIMIT) ? starve_q : starve_q + 4'd1;
      conflict_d  = conflict_q + 32'(if_req_i && d_req_i);
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         owner_q    <= OWN_NONE;
         we_q       <= 1'b0;
         starve_q   <= 4'd0;
         conflict_q <= 32'd0;
      end else begin
         owner_q    <= owner_d;
         we_q       <= we_d;
         starve_q   <= starve_d;
         conflict_q <= conflict_d;
      end
   end
   // Responses are gated by rst_n so a grant issued just before reset never completes.
   assign if_rvalid_o    = rst_n && owner_q == OWN_IF;
   assign d_rvalid_o     = rst_n && owner_q == OWN_D;
   assign if_rdata_o     = if_rvalid_o ? mem_rdata_i : '0;
   assign d_rdata_o      = (d_rvalid_o && !we_q) ? mem_rdata_i : '0;
   assign conflict_cnt_o = conflict_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized checks of mem_arbiter against a behavioural model
module tb_mem_arbiter;
   localparam int LIMIT = 4;
   logic        clk = 1'b0, rst_n = 1'b0;
   logic        if_req_i = 1'b0, d_req_i = 1'b0, d_we_i = 1'b0;
   logic [31:0] if_addr_i = '0, d_addr_i = '0, d_wdata_i = '0, mem_rdata_i = '0;
   logic        if_gnt_o, if_rvalid_o, d_gnt_o, d_rvalid_o, mem_req_o, mem_we_o;
   logic [31:0] if_rdata_o, d_rdata_o, mem_addr_o, mem_wdata_o, conflict_cnt_o;
   int tests = 0, fails = 0;
   int starve_m = 0, owner_m = 0;
   bit we_m = 0;
   logic [31:0] conf_m = '0;

   mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(LIMIT)) dut (
      .clk(clk), .rst_n(rst_n),
      .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
      .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
      .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
      .d_gnt_o(d_gnt_o), .d_rvalid_o(d_rvalid_o), .d_rdata_o(d_rdata_o),
      .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
      .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .conflict_cnt_o(conflict_cnt_o)
   );

   always #5 clk = ~clk;

   // Fetch wins only when it requests alone or has been refused LIMIT cycles in a row.
   function automatic bit e_if_gnt();
      return rst_n && if_req_i && (!d_req_i || starve_m == LIMIT);
   endfunction
   function automatic bit e_d_gnt();
      return rst_n && d_req_i && !e_if_gnt();
   endfunction

   task automatic tick();
      bit gi, gd;
      @(posedge clk);
      gi = e_if_gnt();
      gd = e_d_gnt();
      if (!rst_n) begin
         starve_m = 0; owner_m = 0; we_m = 0; conf_m = '0;
      end else begin
         owner_m  = gi ? 1 : gd ? 2 : 0;
         we_m     = gd && d_we_i;
         starve_m = (if_req_i && !gi) ? ((starve_m < LIMIT) ? starve_m + 1 : LIMIT) : 0;
         if (if_req_i && d_req_i) conf_m = conf_m + 32'd1;
      end
      @(negedge clk);
   endtask

   task automatic idle();
      if_req_i = 0; d_req_i = 0; d_we_i = 0;
   endtask

   task automatic do_reset();
      idle(); rst_n = 0; tick(); rst_n = 1;
   endtask

   task automatic test_reset();
      rst_n = 0; if_req_i = 1; d_req_i = 1; d_we_i = 1;
      tick();
      #1;
      tests += 4;
      if (if_gnt_o !== 1'b0) begin fails++; $display("FAIL reset_if_gnt got %b expected 0", if_gnt_o); end
      if (d_gnt_o !== 1'b0) begin fails++; $display("FAIL reset_d_gnt got %b expected 0", d_gnt_o); end
      if (mem_req_o !== 1'b0) begin fails++; $display("FAIL reset_mem_req got %b expected 0", mem_req_o); end
      if (mem_we_o !== 1'b0) begin fails++; $display("FAIL reset_mem_we got %b expected 0", mem_we_o); end
      tick();
      tests += 3;
      if (if_rvalid_o !== 1'b0 || d_rvalid_o !== 1'b0) begin fails++; $display("FAIL reset_rvalid got %b%b expected 00", if_rvalid_o, d_rvalid_o); end
      if (if_rdata_o !== 32'd0 || d_rdata_o !== 32'd0) begin fails++; $display("FAIL reset_rdata got %h/%h expected 0", if_rdata_o, d_rdata_o); end
      if (conflict_cnt_o !== 32'd0) begin fails++; $display("FAIL reset_conflict got %0d expected 0", conflict_cnt_o); end
      idle(); rst_n = 1;
   endtask

   task automatic test_fetch_read();
      if_req_i = 1; if_addr_i = 32'h100;
      #1;
      tests += 4;
      if (if_gnt_o !== 1'b1) begin fails++; $display("FAIL fetch_gnt got %b expected 1", if_gnt_o); end
      if (d_gnt_o !== 1'b0) begin fails++; $display("FAIL fetch_d_gnt got %b expected 0", d_gnt_o); end
      if (mem_req_o !== 1'b1 || mem_we_o !== 1'b0) begin fails++; $display("FAIL fetch_mem_cmd got req=%b we=%b expected req=1 we=0", mem_req_o, mem_we_o); end
      if (mem_addr_o !== 32'h100) begin fails++; $display("FAIL fetch_mem_addr got %h expected 00000100", mem_addr_o); end
      tick();
      idle(); mem_rdata_i = 32'hDEADBEEF;
      #1;
      tests += 3;
      if (if_rvalid_o !== 1'b1) begin fails++; $display("FAIL fetch_rvalid got %b expected 1", if_rvalid_o); end
      if (if_rdata_o !== 32'hDEADBEEF) begin fails++; $display("FAIL fetch_rdata got %h expected deadbeef", if_rdata_o); end
      if (d_rvalid_o !== 1'b0) begin fails++; $display("FAIL fetch_d_rvalid got %b expected 0", d_rvalid_o); end
      tick();
   endtask

   task automatic test_data_write();
      d_req_i = 1; d_we_i = 1; d_addr_i = 32'h40; d_wdata_i = 32'h12345678;
      #1;
      tests += 3;
      if (d_gnt_o !== 1'b1 || if_gnt_o !== 1'b0) begin fails++; $display("FAIL write_gnt got d=%b if=%b expected d=1 if=0", d_gnt_o, if_gnt_o); end
      if (mem_we_o !== 1'b1 || mem_addr_o !== 32'h40) begin fails++; $display("FAIL write_mem_cmd got we=%b addr=%h expected we=1 addr=00000040", mem_we_o, mem_addr_o); end
      if (mem_wdata_o !== 32'h12345678) begin fails++; $display("FAIL write_wdata got %h expected 12345678", mem_wdata_o); end
      tick();
      idle(); mem_rdata_i = 32'hCAFEF00D;
      #1;
      tests += 2;
      if (d_rvalid_o !== 1'b1) begin fails++; $display("FAIL write_rvalid got %b expected 1", d_rvalid_o); end
      if (d_rdata_o !== 32'd0) begin fails++; $display("FAIL write_rdata got %h expected 0", d_rdata_o); end
      tick();
   endtask

   task automatic test_starvation();
      do_reset();
      for (int k = 1; k <= 10; k++) begin
         if_req_i = 1; d_req_i = 1; d_we_i = 0;
         #1;
         tests++;
         if (if_gnt_o !== (k % 5 == 0) || d_gnt_o !== (k % 5 != 0)) begin
            fails++; $display("FAIL starve_cycle%0d got if=%b d=%b expected if=%b", k, if_gnt_o, d_gnt_o, k % 5 == 0);
         end
         tick();
      end
      idle();
      tests++;
      if (conflict_cnt_o !== 32'd10) begin fails++; $display("FAIL starve_conflict got %0d expected 10", conflict_cnt_o); end
      tick();
   endtask

   task automatic test_back_to_back();
      for (int k = 0; k < 8; k++) begin
         if_req_i = (k % 2 == 0); d_req_i = (k % 2 == 1); d_we_i = 0;
         if_addr_i = $urandom; d_addr_i = $urandom; mem_rdata_i = $urandom;
         #1;
         tests++;
         if (if_gnt_o !== (k % 2 == 0) || d_gnt_o !== (k % 2 == 1)) begin
            fails++; $display("FAIL b2b_gnt%0d got if=%b d=%b", k, if_gnt_o, d_gnt_o);
         end
         if (k > 0) begin
            tests += 2;
            if (if_rvalid_o !== (k % 2 == 1) || d_rvalid_o !== (k % 2 == 0)) begin
               fails++; $display("FAIL b2b_rvalid%0d got if=%b d=%b", k, if_rvalid_o, d_rvalid_o);
            end
            if ((k % 2 == 1 ? if_rdata_o : d_rdata_o) !== mem_rdata_i) begin
               fails++; $display("FAIL b2b_rdata%0d got %h/%h expected %h", k, if_rdata_o, d_rdata_o, mem_rdata_i);
            end
         end
         tick();
      end
      idle(); tick();
   endtask

   task automatic test_reset_mid();
      d_req_i = 1; d_we_i = 0; d_addr_i = 32'h80;
      #1;
      tests++;
      if (d_gnt_o !== 1'b1) begin fails++; $display("FAIL midrst_gnt got %b expected 1", d_gnt_o); end
      tick();
      rst_n = 0; if_req_i = 1; d_req_i = 1; mem_rdata_i = 32'h55AA55AA;
      #1;
      tests += 3;
      if (d_rvalid_o !== 1'b0 || d_rdata_o !== 32'd0) begin fails++; $display("FAIL midrst_rvalid got %b/%h expected 0", d_rvalid_o, d_rdata_o); end
      if (if_gnt_o !== 1'b0 || d_gnt_o !== 1'b0) begin fails++; $display("FAIL midrst_gnt_low got if=%b d=%b expected 0", if_gnt_o, d_gnt_o); end
      if (mem_req_o !== 1'b0) begin fails++; $display("FAIL midrst_mem_req got %b expected 0", mem_req_o); end
      tick();
      rst_n = 1; idle();
      #1;
      tests += 2;
      if (conflict_cnt_o !== 32'd0) begin fails++; $display("FAIL midrst_conflict got %0d expected 0", conflict_cnt_o); end
      if (d_rvalid_o !== 1'b0) begin fails++; $display("FAIL midrst_late_rvalid got %b expected 0", d_rvalid_o); end
      tick();
   endtask

   task automatic test_wrap();
      force dut.conflict_q = 32'hFFFFFFFF;
      #1;
      release dut.conflict_q;
      conf_m = 32'hFFFFFFFF;
      if_req_i = 1; d_req_i = 1;
      #1;
      tests++;
      if (conflict_cnt_o !== 32'hFFFFFFFF) begin fails++; $display("FAIL wrap_preload got %h expected ffffffff", conflict_cnt_o); end
      tick();
      idle();
      tests++;
      if (conflict_cnt_o !== 32'd0) begin fails++; $display("FAIL wrap_zero got %h expected 0", conflict_cnt_o); end
      tick();
   endtask

   task automatic test_random();
      bit gi, gd, ri, rd;
      for (int n = 0; n < 400; n++) begin
         rst_n = ($urandom_range(0, 19) != 0);
         if_req_i = $urandom_range(0, 3) != 0; d_req_i = $urandom_range(0, 2) != 0;
         d_we_i = $urandom; if_addr_i = $urandom; d_addr_i = $urandom;
         d_wdata_i = $urandom; mem_rdata_i = $urandom;
         #1;
         gi = e_if_gnt(); gd = e_d_gnt();
         ri = rst_n && owner_m == 1; rd = rst_n && owner_m == 2;
         tests += 7;
         if (if_gnt_o !== gi || d_gnt_o !== gd) begin fails++; $display("FAIL rnd_gnt%0d got if=%b d=%b expected if=%b d=%b", n, if_gnt_o, d_gnt_o, gi, gd); end
         if (mem_req_o !== (gi | gd) || mem_we_o !== (gd && d_we_i)) begin fails++; $display("FAIL rnd_mem_cmd%0d got req=%b we=%b expected req=%b we=%b", n, mem_req_o, mem_we_o, gi | gd, gd && d_we_i); end
         if ((gi || gd) && mem_addr_o !== (gd ? d_addr_i : if_addr_i)) begin fails++; $display("FAIL rnd_addr%0d got %h expected %h", n, mem_addr_o, gd ? d_addr_i : if_addr_i); end
         if (gd && mem_wdata_o !== d_wdata_i) begin fails++; $display("FAIL rnd_wdata%0d got %h expected %h", n, mem_wdata_o, d_wdata_i); end
         if (if_rvalid_o !== ri || d_rvalid_o !== rd) begin fails++; $display("FAIL rnd_rvalid%0d got if=%b d=%b expected if=%b d=%b", n, if_rvalid_o, d_rvalid_o, ri, rd); end
         if (if_rdata_o !== (ri ? mem_rdata_i : 32'd0) || d_rdata_o !== ((rd && !we_m) ? mem_rdata_i : 32'd0)) begin
            fails++; $display("FAIL rnd_rdata%0d got %h/%h", n, if_rdata_o, d_rdata_o);
         end
         if (conflict_cnt_o !== conf_m) begin fails++; $display("FAIL rnd_conflict%0d got %0d expected %0d", n, conflict_cnt_o, conf_m); end
         tick();
      end
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_fetch_read();
      test_data_write();
      test_starvation();
      test_back_to_back();
      test_reset_mid();
      test_wrap();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
